// File: rtl/aes_encrypt_iter.sv
// Iterative AES encrypt core: one round per clock, AES-128/192/256 via Nk.
// Round 0 is folded into accept; the final round (no MixColumns) writes out.
module aes_encrypt_iter #(
  parameter int Nk = 4,
  localparam int Nr = Nk + 6,
  localparam int N = 32 * Nk
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam int NW = 4 * (Nr + 1);
  localparam int FW = 128 * (Nr + 1);
  localparam int RW = $clog2(Nr + 1);
  localparam logic [RW-1:0] RLAST = RW'(Nr);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_encrypt_iter: Nk must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), b);
    r = gmul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
         ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte k sits at [127-8k -: 8]; k = 4*col + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_rkey(
    input logic [127:0] s,
    input logic [127:0] k
  );
    return s ^ k;
  endfunction

  function automatic logic [127:0] encrypt_round(
    input logic [127:0] s,
    input logic [127:0] k
  );
    return add_rkey(mix_columns(shift_rows(sub_bytes(s))), k);
  endfunction

  // Full schedule, word 0 in the MSBs; 256-bit keys add the mid SubWord.
  function automatic logic [FW-1:0] key_expansion(input logic [N-1:0] k);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0] rc;
    logic [FW-1:0] f;
    rc = 8'h01;
    for (int i = 0; i < Nk; i++) w[i] = k[N-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    for (int i = 0; i < NW; i++) f[FW-1-32*i -: 32] = w[i];
    return f;
  endfunction

  state_t        fsm;
  logic [RW-1:0] rnd;
  logic [127:0]  st_q;
  logic [N-1:0]  key_q;
  logic [FW-1:0] fk;
  logic [127:0]  rk;
  logic [127:0]  nxt_st;
  logic [127:0]  fin;
  logic          accept;

  assign fk = key_expansion(key_q);
  assign rk = fk[FW-1-128*int'(rnd) -: 128];
  assign nxt_st = encrypt_round(st_q, rk);
  assign fin = add_rkey(shift_rows(sub_bytes(st_q)), rk);

  assign in_ready = rst_n & ((fsm == IDLE) | ((fsm == DONE) & out_ready));
  assign accept = in_valid & in_ready;
  assign out_valid = (fsm == DONE);
  assign busy = (fsm == ROUND);

  // Control FSM plus round datapath; in/key are captured only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      rnd   <= '0;
      st_q  <= '0;
      key_q <= '0;
      out   <= '0;
    end else begin
      unique case (fsm)
        IDLE, DONE: begin
          if (accept) begin
            key_q <= key;
            st_q  <= in ^ key[N-1 -: 128];
            rnd   <= RW'(1);
            fsm   <= ROUND;
          end else if (fsm == DONE && out_ready) begin
            fsm <= IDLE;
          end
        end
        ROUND: begin
          if (rnd < RLAST) begin
            st_q <= nxt_st;
            rnd  <= rnd + RW'(1);
          end else begin
            out <= fin;
            fsm <= DONE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 vectors on all key sizes,
// latency, stall, back-to-back, mid-run reset and input isolation.
module tb_aes_encrypt_iter;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K6  =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K8  = {128'h000102030405060708090a0b0c0d0e0f,
                                  128'h101112131415161718191a1b1c1d1e1f};
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT3 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] din = '0;
  logic         iv4 = 1'b0, iv6 = 1'b0, iv8 = 1'b0;
  logic [127:0] key4 = '0;
  logic [191:0] key6 = '0;
  logic [255:0] key8 = '0;
  logic         ir4, ir6, ir8, ov4, ov6, ov8, busy4, busy6, busy8;
  logic [127:0] dout4, dout6, dout8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.Nk(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in(din), .key(key4), .out_valid(ov4), .out_ready(out_ready),
    .out(dout4), .busy(busy4)
  );

  aes_encrypt_iter #(.Nk(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6),
    .in(din), .key(key6), .out_valid(ov6), .out_ready(out_ready),
    .out(dout6), .busy(busy6)
  );

  aes_encrypt_iter #(.Nk(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in(din), .key(key8), .out_valid(ov8), .out_ready(out_ready),
    .out(dout8), .busy(busy8)
  );

  task automatic start4(input logic [127:0] pt, input logic [127:0] k);
    int g;
    g = 0;
    @(negedge clk);
    din = pt;
    key4 = k;
    iv4 = 1'b1;
    while (!ir4 && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
  endtask

  task automatic wait4(output int cyc);
    cyc = 0;
    while (!ov4 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ov4 !== 1'b0 || busy4 !== 1'b0 || ir4 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: ov=%b busy=%b ir=%b want 0 0 0",
               ov4, busy4, ir4);
    end
    n_cmp++;
    if (dout4 !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0", dout4);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ir4 !== 1'b1 || ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: ir4=%b ir8=%b want 1 1", ir4, ir8);
    end
  endtask

  task automatic test_vec1;
    int c;
    start4(PT1, K1);
    n_cmp++;
    if (busy4 !== 1'b1 || ir4 !== 1'b0) begin
      n_bad++;
      $display("FAIL vec1_busy: busy=%b ir=%b want 1 0", busy4, ir4);
    end
    wait4(c);
    n_cmp++;
    if (c !== 10) begin
      n_bad++;
      $display("FAIL vec1_latency: got %0d want 10", c);
    end
    n_cmp++;
    if (dout4 !== CT1) begin
      n_bad++;
      $display("FAIL vec1_out: got %h want %h", dout4, CT1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (ov4 !== 1'b0 || busy4 !== 1'b0 || dout4 !== CT1) begin
      n_bad++;
      $display("FAIL vec1_release: ov=%b busy=%b out=%h want 0 0 %h",
               ov4, busy4, dout4, CT1);
    end
  endtask

  task automatic test_key_sizes;
    int c, l6, l8;
    @(negedge clk);
    din = PT1;
    key6 = K6;
    key8 = K8;
    iv6 = 1'b1;
    iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv6 = 1'b0;
    iv8 = 1'b0;
    c = 0;
    l6 = -1;
    l8 = -1;
    while ((l6 < 0 || l8 < 0) && c < 40) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (ov6 && l6 < 0) l6 = c;
      if (ov8 && l8 < 0) l8 = c;
    end
    n_cmp++;
    if (l6 !== 12) begin
      n_bad++;
      $display("FAIL nk6_latency: got %0d want 12", l6);
    end
    n_cmp++;
    if (dout6 !== CT6) begin
      n_bad++;
      $display("FAIL nk6_out: got %h want %h", dout6, CT6);
    end
    n_cmp++;
    if (l8 !== 14) begin
      n_bad++;
      $display("FAIL nk8_latency: got %0d want 14", l8);
    end
    n_cmp++;
    if (dout8 !== CT8) begin
      n_bad++;
      $display("FAIL nk8_out: got %h want %h", dout8, CT8);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_stall;
    int c;
    start4(PT3, K3);
    wait4(c);
    n_cmp++;
    if (c !== 10 || dout4 !== CT3) begin
      n_bad++;
      $display("FAIL vec3_out: got %h after %0d want %h after 10",
               dout4, c, CT3);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (dout4 !== CT3 || ov4 !== 1'b1 || ir4 !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold: cyc %0d out=%h ov=%b ir=%b", i,
                 dout4, ov4, ir4);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (ov4 !== 1'b0 || dout4 !== CT3 || ir4 !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release: ov=%b out=%h ir=%b want 0 %h 1",
               ov4, dout4, ir4, CT3);
    end
  endtask

  task automatic test_back_to_back;
    int t, t1;
    @(negedge clk);
    din = PT1;
    key4 = K1;
    iv4 = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din = PT3;
    key4 = K3;
    t = 0;
    while (!ov4 && t < 40) begin
      @(posedge clk);
      t++;
      @(negedge clk);
    end
    t1 = t;
    n_cmp++;
    if (t1 !== 10 || dout4 !== CT1) begin
      n_bad++;
      $display("FAIL b2b_first: got %h after %0d want %h after 10",
               dout4, t1, CT1);
    end
    n_cmp++;
    if (ir4 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got %b want 1", ir4);
    end
    @(posedge clk);
    t++;
    @(negedge clk);
    iv4 = 1'b0;
    n_cmp++;
    if (ov4 !== 1'b0 || busy4 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_no_bubble: ov=%b busy=%b want 0 1", ov4, busy4);
    end
    while (!ov4 && t < 80) begin
      @(posedge clk);
      t++;
      @(negedge clk);
    end
    n_cmp++;
    if (t - t1 !== 11) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d want 11", t - t1);
    end
    n_cmp++;
    if (dout4 !== CT3) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want %h", dout4, CT3);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int c;
    start4(PT1, K1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dout4 !== 128'h0 || ov4 !== 1'b0 || busy4 !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_clear: out=%h ov=%b busy=%b want 0 0 0",
               dout4, ov4, busy4);
    end
    @(negedge clk);
    n_cmp++;
    if (ir4 !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_ready: got %b want 0", ir4);
    end
    rst_n = 1'b1;
    start4(PT3, K3);
    wait4(c);
    n_cmp++;
    if (c !== 10 || dout4 !== CT3) begin
      n_bad++;
      $display("FAIL midreset_after: got %h after %0d want %h after 10",
               dout4, c, CT3);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_change_inputs;
    int c;
    @(negedge clk);
    din = PT3;
    key4 = K3;
    iv4 = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    c = 0;
    @(negedge clk);
    while (!ov4 && c < 40) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      key4 = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    n_cmp++;
    if (c !== 10 || dout4 !== CT3) begin
      n_bad++;
      $display("FAIL isolate_out: got %h after %0d want %h after 10",
               dout4, c, CT3);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dout4 !== CT3 || ov4 !== 1'b1) begin
      n_bad++;
      $display("FAIL isolate_hold: out=%h ov=%b want %h 1", dout4, ov4,
               CT3);
    end
    iv4 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vec1();
    test_key_sizes();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_change_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
